// File: rtl/dma_read_loader.sv
// dma_read_loader
//   Multi-segment DMA read engine. A start pulse latches a table of NUM_SEG
//   descriptors (DRAM word index, word length, SRAM word base). For every
//   enabled, non-empty segment one DMA read control request is issued. The
//   returned DMA_W-bit beats are then forwarded as lane-packed SRAM write
//   commands tagged with the segment id.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   start                    one-cycle launch pulse (sampled only in IDLE)
//   seg_en/index/length/base descriptor table, latched on start
//   busy, done               run status, one-cycle completion pulse
//   dma_read_ctrl_*          control request channel (valid/ready)
//   dma_read_chnl_*          read data channel (valid/ready)
//   wr_en/seg/addr/mask/data SRAM write command, one cycle per beat
//   beat_cnt                 beats accepted since the last start
module dma_read_loader #(
  parameter int         DMA_W     = 64,
  parameter int         WORD_W    = 32,
  parameter int         ADDR_W    = 16,
  parameter int         NUM_SEG   = 2,
  parameter logic [2:0] SIZE_CODE = 3'b010
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [NUM_SEG-1:0]                            seg_en,
  input  logic [NUM_SEG*32-1:0]                         seg_index,
  input  logic [NUM_SEG*32-1:0]                         seg_length,
  input  logic [NUM_SEG*ADDR_W-1:0]                     seg_base,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          dma_read_ctrl_valid,
  input  logic                                          dma_read_ctrl_ready,
  output logic [31:0]                                   dma_read_ctrl_data_index,
  output logic [31:0]                                   dma_read_ctrl_data_length,
  output logic [2:0]                                    dma_read_ctrl_data_size,
  input  logic                                          dma_read_chnl_valid,
  output logic                                          dma_read_chnl_ready,
  input  logic [DMA_W-1:0]                              dma_read_chnl_data,
  output logic                                          wr_en,
  output logic [((NUM_SEG > 1) ? $clog2(NUM_SEG) : 1)-1:0] wr_seg,
  output logic [ADDR_W-1:0]                             wr_addr,
  output logic [DMA_W/WORD_W-1:0]                       wr_mask,
  output logic [DMA_W-1:0]                              wr_data,
  output logic [31:0]                                   beat_cnt
);

  localparam int LANES = DMA_W / WORD_W;
  localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_CTRL, S_CHNL, S_FIN} state_t;

  state_t              r_state;
  logic [SEG_W-1:0]    r_seg;
  logic [31:0]         r_rem;
  logic [ADDR_W-1:0]   r_addr;
  logic [NUM_SEG-1:0]  r_en;
  logic [31:0]         r_idx  [NUM_SEG];
  logic [31:0]         r_len  [NUM_SEG];
  logic [ADDR_W-1:0]   r_base [NUM_SEG];

  logic [31:0]         w_step;
  logic [LANES-1:0]    w_mask;
  logic                w_last_seg;
  logic                w_skip;

  always_comb begin
    w_step     = (r_rem >= 32'(LANES)) ? 32'(LANES) : r_rem;
    // Lane k is live while more than k words remain; gives all ones on full beats.
    w_mask     = '0;
    for (int k = 0; k < LANES; k++) begin
      w_mask[k] = (r_rem > 32'(k));
    end
    w_last_seg = (r_seg == SEG_W'(NUM_SEG - 1));
    w_skip     = !r_en[r_seg] || (r_len[r_seg] == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state                   <= S_IDLE;
      r_seg                     <= '0;
      r_rem                     <= '0;
      r_addr                    <= '0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      dma_read_ctrl_valid       <= 1'b0;
      dma_read_ctrl_data_index  <= '0;
      dma_read_ctrl_data_length <= '0;
      dma_read_ctrl_data_size   <= SIZE_CODE;
      dma_read_chnl_ready       <= 1'b0;
      wr_en                     <= 1'b0;
      wr_seg                    <= '0;
      wr_addr                   <= '0;
      wr_mask                   <= '0;
      wr_data                   <= '0;
      beat_cnt                  <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_en <= seg_en;
            for (int i = 0; i < NUM_SEG; i++) begin
              r_idx[i]  <= seg_index[i*32 +: 32];
              r_len[i]  <= seg_length[i*32 +: 32];
              r_base[i] <= seg_base[i*ADDR_W +: ADDR_W];
            end
            r_seg    <= '0;
            beat_cnt <= '0;
            busy     <= 1'b1;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_skip) begin
            if (w_last_seg) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_FIN;
            end else begin
              r_seg <= r_seg + SEG_W'(1);
            end
          end else begin
            r_rem                     <= r_len[r_seg];
            r_addr                    <= r_base[r_seg];
            dma_read_ctrl_valid       <= 1'b1;
            dma_read_ctrl_data_index  <= r_idx[r_seg];
            dma_read_ctrl_data_length <= r_len[r_seg];
            r_state                   <= S_CTRL;
          end
        end
        S_CTRL: begin
          if (dma_read_ctrl_ready) begin
            dma_read_ctrl_valid <= 1'b0;
            dma_read_chnl_ready <= 1'b1;
            r_state             <= S_CHNL;
          end
        end
        S_CHNL: begin
          if (dma_read_chnl_valid && dma_read_chnl_ready) begin
            wr_en    <= 1'b1;
            wr_seg   <= r_seg;
            wr_addr  <= r_addr;
            wr_mask  <= w_mask;
            wr_data  <= dma_read_chnl_data;
            r_rem    <= r_rem - w_step;
            r_addr   <= r_addr + ADDR_W'(LANES);
            beat_cnt <= beat_cnt + 32'd1;
            // Final beat of this segment: this beat consumes every remaining word.
            if (r_rem == w_step) begin
              dma_read_chnl_ready <= 1'b0;
              if (w_last_seg) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_FIN;
              end else begin
                r_seg   <= r_seg + SEG_W'(1);
                r_state <= S_SCAN;
              end
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_loader.sv
// Testbench for dma_read_loader: a queue-based reference model derived from
// the descriptor table predicts every control request and SRAM write; a
// per-cycle monitor compares the DUT against it, and directed scenarios pin
// the model with hand-computed values.
module tb_dma_read_loader;
  localparam int DMA_W   = 64;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int NUM_SEG = 2;
  localparam int LANES   = DMA_W / WORD_W;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [NUM_SEG-1:0]        seg_en;
  logic [NUM_SEG*32-1:0]     seg_index;
  logic [NUM_SEG*32-1:0]     seg_length;
  logic [NUM_SEG*ADDR_W-1:0] seg_base;
  logic                      busy, done;
  logic                      ctrl_valid, ctrl_ready;
  logic [31:0]               ctrl_index, ctrl_length;
  logic [2:0]                ctrl_size;
  logic                      chnl_valid, chnl_ready;
  logic [DMA_W-1:0]          chnl_data;
  logic                      wr_en;
  logic [0:0]                wr_seg;
  logic [ADDR_W-1:0]         wr_addr;
  logic [LANES-1:0]          wr_mask;
  logic [DMA_W-1:0]          wr_data;
  logic [31:0]               beat_cnt;

  always #5 clk = ~clk;

  dma_read_loader #(
    .DMA_W(DMA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_SEG(NUM_SEG), .SIZE_CODE(3'b010)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .seg_en(seg_en), .seg_index(seg_index), .seg_length(seg_length), .seg_base(seg_base),
    .busy(busy), .done(done),
    .dma_read_ctrl_valid(ctrl_valid), .dma_read_ctrl_ready(ctrl_ready),
    .dma_read_ctrl_data_index(ctrl_index), .dma_read_ctrl_data_length(ctrl_length),
    .dma_read_ctrl_data_size(ctrl_size),
    .dma_read_chnl_valid(chnl_valid), .dma_read_chnl_ready(chnl_ready),
    .dma_read_chnl_data(chnl_data),
    .wr_en(wr_en), .wr_seg(wr_seg), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .wr_data(wr_data), .beat_cnt(beat_cnt)
  );

  typedef struct packed { logic [0:0] seg; logic [15:0] addr; logic [1:0] mask; } wexp_t;
  typedef struct packed { logic [31:0] idx; logic [31:0] len; } cexp_t;

  wexp_t exp_wr[$];
  cexp_t exp_ctrl[$];
  cexp_t hs_log[$];
  wexp_t wr_log[$];

  int checks = 0;
  int errors = 0;
  int exp_beats;
  int done_cnt;
  int wr_total;
  int seg_wr_cnt[2];
  logic [15:0] seg_last_addr[2];
  bit mon_en = 1'b0;
  bit pend_beat;
  logic [63:0] pend_data;
  bit prev_cv, prev_cr;
  int mode = 0;
  int cv_wait = 0;

  logic        d_en[2];
  logic [31:0] d_idx[2];
  logic [31:0] d_len[2];
  logic [15:0] d_base[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: requests and writes follow directly from the descriptor table.
  task automatic build_model();
    exp_wr.delete(); exp_ctrl.delete(); exp_beats = 0;
    for (int s = 0; s < 2; s++) begin
      if (d_en[s] && d_len[s] != 0) begin
        int nb;
        exp_ctrl.push_back('{idx: d_idx[s], len: d_len[s]});
        nb = int'((d_len[s] + 32'(LANES) - 1) / 32'(LANES));
        for (int b = 0; b < nb; b++) begin
          logic [31:0] rem;
          wexp_t e;
          rem    = d_len[s] - 32'(LANES * b);
          e.seg  = 1'(s);
          e.addr = d_base[s] + 16'(LANES * b);
          e.mask = (rem >= 32'(LANES)) ? 2'b11 : 2'((64'd1 << rem) - 64'd1);
          exp_wr.push_back(e);
        end
        exp_beats += nb;
      end
    end
  endtask

  // Handshake stimulus, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    chnl_data = {$urandom, $urandom};
    case (mode)
      0: begin ctrl_ready = 1'b1; chnl_valid = 1'b1; end
      1: begin ctrl_ready = 1'($urandom_range(0, 1)); chnl_valid = 1'($urandom_range(0, 1)); end
      default: begin
        cv_wait    = ctrl_valid ? cv_wait + 1 : 0;
        ctrl_ready = (cv_wait > 7);
        chnl_valid = ~chnl_valid;
      end
    endcase
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ctrl_size", ctrl_size, 3'b010);
      chk("wr_en_timing", wr_en, pend_beat);
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          wexp_t e;
          e = exp_wr.pop_front();
          chk("wr_seg", wr_seg, e.seg);
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_mask", wr_mask, e.mask);
          chk("wr_data", wr_data, pend_data);
        end
        wr_log.push_back('{seg: wr_seg, addr: wr_addr, mask: wr_mask});
        wr_total++;
        seg_wr_cnt[wr_seg]++;
        seg_last_addr[wr_seg] = wr_addr;
      end
      if (prev_cv && !prev_cr) chk("ctrl_valid_held", ctrl_valid, 1);
      if (ctrl_valid) begin
        chk("chnl_ready_in_ctrl", chnl_ready, 0);
        if (exp_ctrl.size() == 0) begin
          chk("unexpected_ctrl", 1, 0);
        end else begin
          chk("ctrl_index", ctrl_index, exp_ctrl[0].idx);
          chk("ctrl_length", ctrl_length, exp_ctrl[0].len);
          if (ctrl_ready) begin
            void'(exp_ctrl.pop_front());
            hs_log.push_back('{idx: ctrl_index, len: ctrl_length});
          end
        end
      end
      prev_cv   = ctrl_valid;
      prev_cr   = ctrl_ready;
      pend_beat = chnl_valid && chnl_ready;
      pend_data = chnl_data;
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", busy, 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ctrl_valid"}, ctrl_valid, 0);
    chk({tag, "_ctrl_index"}, ctrl_index, 0);
    chk({tag, "_ctrl_length"}, ctrl_length, 0);
    chk({tag, "_ctrl_size"}, ctrl_size, 3'b010);
    chk({tag, "_chnl_ready"}, chnl_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_seg"}, wr_seg, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_mask"}, wr_mask, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 0);
  endtask

  task automatic setup_job(input logic [1:0] en, input logic [31:0] i0, input logic [31:0] l0,
                           input logic [15:0] b0, input logic [31:0] i1, input logic [31:0] l1,
                           input logic [15:0] b1, input int m);
    d_en[0] = en[0]; d_idx[0] = i0; d_len[0] = l0; d_base[0] = b0;
    d_en[1] = en[1]; d_idx[1] = i1; d_len[1] = l1; d_base[1] = b1;
    seg_en = en; seg_index = {i1, i0}; seg_length = {l1, l0}; seg_base = {b1, b0};
    build_model();
    hs_log.delete(); wr_log.delete();
    done_cnt = 0; wr_total = 0;
    seg_wr_cnt[0] = 0; seg_wr_cnt[1] = 0;
    seg_last_addr[0] = '0; seg_last_addr[1] = '0;
    pend_beat = 1'b0; prev_cv = 1'b0; prev_cr = 1'b0;
    mode = m;
    mon_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] en, input logic [31:0] i0, input logic [31:0] l0,
                         input logic [15:0] b0, input logic [31:0] i1, input logic [31:0] l1,
                         input logic [15:0] b1, input int m, input int restart_at,
                         output int lat);
    bit got = 1'b0;
    bit restarted = 1'b0;
    lat = -1;
    setup_job(en, i0, l0, b0, i1, l1, b1, m);
    for (int cyc = 0; cyc < 30000 && !got; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 0) chk("busy_after_start", busy, 1);
      if (done) begin
        got = 1'b1;
        lat = cyc + 1;
      end else if (restart_at > 0 && wr_total == restart_at && !restarted) begin
        restarted  = 1'b1;
        seg_index  = ~seg_index;
        seg_length = 64'h0000_0003_0000_0001;
        seg_base   = 32'h1234_5678;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    chk("model_writes_drained", exp_wr.size(), 0);
    chk("model_ctrl_drained", exp_ctrl.size(), 0);
    chk("beat_cnt_final", beat_cnt, exp_beats);
    repeat (4) @(negedge clk);
    #1 chk("single_done", done_cnt, 1);
  endtask

  initial begin
    int lat;
    int n;
    bit got;
    rst = 1'b0; start = 1'b0; seg_en = '0; seg_index = '0; seg_length = '0; seg_base = '0;
    ctrl_ready = 1'b0; chnl_valid = 1'b0; chnl_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #1 rst = 1'b1;

    // Two segments, long transfer
    run_job(2'b11, 32'd0, 32'd7880, 16'd0, 32'd10000, 32'd128, 16'd0, 0, 0, lat);
    chk("two_hs_count", hs_log.size(), 2);
    if (hs_log.size() == 2) begin
      chk("two_hs0_idx", hs_log[0].idx, 0);
      chk("two_hs0_len", hs_log[0].len, 7880);
      chk("two_hs1_idx", hs_log[1].idx, 10000);
      chk("two_hs1_len", hs_log[1].len, 128);
    end
    chk("two_seg0_writes", seg_wr_cnt[0], 3940);
    chk("two_seg0_last_addr", seg_last_addr[0], 7878);
    chk("two_seg1_writes", seg_wr_cnt[1], 64);
    chk("two_seg1_last_addr", seg_last_addr[1], 126);
    chk("two_beat_cnt", beat_cnt, 4004);

    // Odd tail
    run_job(2'b01, 32'd5, 32'd5, 16'd100, 32'd0, 32'd0, 16'd0, 0, 0, lat);
    chk("tail_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("tail_a0", wr_log[0].addr, 100); chk("tail_m0", wr_log[0].mask, 2'b11);
      chk("tail_a1", wr_log[1].addr, 102); chk("tail_m1", wr_log[1].mask, 2'b11);
      chk("tail_a2", wr_log[2].addr, 104); chk("tail_m2", wr_log[2].mask, 2'b01);
    end
    run_job(2'b11, 32'd5, 32'd5, 16'd100, 32'd50, 32'd3, 16'd300, 0, 0, lat);
    chk("tail2_count", wr_log.size(), 5);
    if (wr_log.size() == 5) begin
      chk("tail2_a3", wr_log[3].addr, 300); chk("tail2_m3", wr_log[3].mask, 2'b11);
      chk("tail2_a4", wr_log[4].addr, 302); chk("tail2_m4", wr_log[4].mask, 2'b01);
    end

    // Backpressure
    run_job(2'b11, 32'd7, 32'd9, 16'd20, 32'd33, 32'd6, 16'd40, 2, 0, lat);
    chk("bp_hs_count", hs_log.size(), 2);
    chk("bp_writes", wr_total, 8);

    // Skips
    run_job(2'b10, 32'd1, 32'd10, 16'd0, 32'd2, 32'd4, 16'd8, 0, 0, lat);
    chk("skip_en_hs_count", hs_log.size(), 1);
    if (hs_log.size() == 1) chk("skip_en_hs_idx", hs_log[0].idx, 2);
    chk("skip_en_seg0_writes", seg_wr_cnt[0], 0);
    chk("skip_en_seg1_writes", seg_wr_cnt[1], 2);
    run_job(2'b11, 32'd1, 32'd0, 16'd0, 32'd2, 32'd4, 16'd8, 0, 0, lat);
    chk("skip_len_hs_count", hs_log.size(), 1);
    chk("skip_len_seg1_writes", seg_wr_cnt[1], 2);
    run_job(2'b00, 32'd1, 32'd10, 16'd0, 32'd2, 32'd4, 16'd8, 0, 0, lat);
    chk("skip_all_hs_count", hs_log.size(), 0);
    chk("skip_all_latency", lat, 3);

    // Address wrap
    run_job(2'b01, 32'd9, 32'd6, 16'hFFFE, 32'd0, 32'd0, 16'd0, 1, 0, lat);
    if (wr_log.size() == 3) chk("wrap_addr1", wr_log[1].addr, 16'h0000);
    else chk("wrap_count", wr_log.size(), 3);

    // Reset mid-CHNL
    setup_job(2'b01, 32'd4, 32'd60, 16'd0, 32'd0, 32'd0, 16'd0, 0);
    got = 1'b0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      @(negedge clk); #1;
      if (wr_total >= 10) got = 1'b1;
    end
    if (!got) chk("reset_wait_timeout", 0, 1);
    mon_en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    #1 rst = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_done_after_reset", n, 0);
    run_job(2'b11, 32'd4, 32'd60, 16'd0, 32'd8, 32'd7, 16'd500, 0, 0, lat);

    // Start while busy
    run_job(2'b11, 32'd3, 32'd20, 16'd0, 32'd4, 32'd10, 16'd64, 0, 4, lat);
    chk("restart_hs_count", hs_log.size(), 2);

    // Randomised jobs
    for (int r = 0; r < 10; r++) begin
      run_job(2'($urandom_range(0, 3)),
              $urandom, 32'($urandom_range(0, 40)), 16'($urandom),
              $urandom, 32'($urandom_range(0, 40)), 16'($urandom),
              int'($urandom_range(0, 2)), 0, lat);
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
